// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of a single-port registered-read RAM between two requesters
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  A_REQ,
  input  logic                  A_WE,
  input  logic [ADDR_WIDTH-1:0] A_ADDR,
  input  logic [DATA_WIDTH-1:0] A_WDATA,
  output logic                  A_GNT,
  output logic                  A_RVALID,
  output logic [DATA_WIDTH-1:0] A_RDATA,
  input  logic                  B_REQ,
  input  logic                  B_WE,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  input  logic [DATA_WIDTH-1:0] B_WDATA,
  output logic                  B_GNT,
  output logic                  B_RVALID,
  output logic [DATA_WIDTH-1:0] B_RDATA,
  output logic                  RAM_ENABLE,
  output logic                  RAM_WRITE,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DATA_IN,
  input  logic [DATA_WIDTH-1:0] RAM_DATA_OUT
);
  logic                  last_q, last_d;
  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic                  own_q, own_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  arv_q, arv_d;
  logic                  brv_q, brv_d;
  logic                  xfer;
  // last_q high means B won most recently, so a tie goes to A
  assign A_GNT = RST_N & A_REQ & (~B_REQ | last_q);
  assign B_GNT = RST_N & B_REQ & (~A_REQ | ~last_q);
  assign xfer  = A_GNT | B_GNT;
  // next command, owner and read-return state
  always_comb begin
    last_d = xfer ? B_GNT : last_q;
    en_d   = xfer;
    we_d   = xfer & (B_GNT ? B_WE : A_WE);
    own_d  = B_GNT;
    addr_d = xfer ? (B_GNT ? B_ADDR : A_ADDR) : addr_q;
    data_d = xfer ? (B_GNT ? B_WDATA : A_WDATA) : data_q;
    arv_d  = en_q & ~we_q & ~own_q;
    brv_d  = en_q & ~we_q & own_q;
  end
  // command and read-valid pipeline, cleared asynchronously so in-flight reads are dropped
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_q <= 1'b1;
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      own_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      arv_q  <= 1'b0;
      brv_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      en_q   <= en_d;
      we_q   <= we_d;
      own_q  <= own_d;
      addr_q <= addr_d;
      data_q <= data_d;
      arv_q  <= arv_d;
      brv_q  <= brv_d;
    end
  end
  assign RAM_ENABLE  = en_q;
  assign RAM_WRITE   = we_q;
  assign RAM_ADDR    = addr_q;
  assign RAM_DATA_IN = data_q;
  assign A_RVALID    = arv_q;
  assign B_RVALID    = brv_q;
  assign A_RDATA     = RAM_DATA_OUT;
  assign B_RDATA     = RAM_DATA_OUT;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized two-port traffic against a transaction-level reference model
module tb_ram_port_arbiter;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        A_REQ, A_WE, B_REQ, B_WE;
  logic [15:0] A_ADDR, A_WDATA, B_ADDR, B_WDATA;
  logic        A_GNT, A_RVALID, B_GNT, B_RVALID;
  logic [15:0] A_RDATA, B_RDATA;
  logic        RAM_ENABLE, RAM_WRITE;
  logic [15:0] RAM_ADDR, RAM_DATA_IN, RAM_DATA_OUT;
  logic [15:0] ram [4096];
  logic [15:0] ref_mem [4096];
  int          checks = 0;
  int          errors = 0;
  logic        last_b, ga, gb, ega, egb;
  logic        c_en, c_we, c_own;
  logic [15:0] c_addr, c_din;
  logic        rva_exp, rvb_exp;
  logic [15:0] r_exp;
  int          prob;
  always #5 CLK = ~CLK;
  ram_port_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
    .RAM_ENABLE(RAM_ENABLE), .RAM_WRITE(RAM_WRITE), .RAM_ADDR(RAM_ADDR),
    .RAM_DATA_IN(RAM_DATA_IN), .RAM_DATA_OUT(RAM_DATA_OUT)
  );
  // behavioural single-port RAM, 4K words, registered read
  always @(posedge CLK)
    if (RAM_ENABLE) begin
      if (RAM_WRITE) ram[RAM_ADDR[11:0]] <= RAM_DATA_IN;
      else RAM_DATA_OUT <= ram[RAM_ADDR[11:0]];
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    last_b = 1'b1;
    c_en = 0; c_we = 0; c_own = 0; c_addr = 0; c_din = 0;
    rva_exp = 0; rvb_exp = 0; r_exp = 0;
    ga = 0; gb = 0;
  endtask
  task automatic new_a();
    A_REQ = ($urandom_range(0, 99) < prob);
    A_WE = 1'($urandom);
    A_ADDR = {4'($urandom), 8'h00, 4'($urandom)};
    A_WDATA = 16'($urandom);
  endtask
  task automatic new_b();
    B_REQ = ($urandom_range(0, 99) < prob);
    B_WE = 1'($urandom);
    B_ADDR = {4'($urandom), 8'h00, 4'($urandom)};
    B_WDATA = 16'($urandom);
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 16'($urandom);
      ref_mem[i] = ram[i];
    end
    RST_N = 1'b0;
    A_REQ = 1; A_WE = 0; A_ADDR = 0; A_WDATA = 0;
    B_REQ = 1; B_WE = 0; B_ADDR = 0; B_WDATA = 0;
    model_reset();
    @(negedge CLK);
    chk("rst_a_gnt", A_GNT, 0);
    chk("rst_b_gnt", B_GNT, 0);
    chk("rst_en", RAM_ENABLE, 0);
    chk("rst_addr", RAM_ADDR, 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge CLK);
      #1;
      prob = cyc < 1000 ? 50 : cyc < 2000 ? 100 : 20;
      RST_N = !(cyc > 2 && $urandom_range(0, 99) == 0);
      if (!A_REQ || ga) new_a();
      if (!B_REQ || gb) new_b();
      @(negedge CLK);
      if (!RST_N) begin
        chk("rst_a_gnt", A_GNT, 0);
        chk("rst_b_gnt", B_GNT, 0);
        chk("rst_en", RAM_ENABLE, 0);
        chk("rst_we", RAM_WRITE, 0);
        chk("rst_addr", RAM_ADDR, 0);
        chk("rst_din", RAM_DATA_IN, 0);
        chk("rst_a_rvalid", A_RVALID, 0);
        chk("rst_b_rvalid", B_RVALID, 0);
        model_reset();
      end else begin
        ega = A_REQ && (!B_REQ || last_b);
        egb = B_REQ && (!A_REQ || !last_b);
        chk("a_gnt", A_GNT, ega);
        chk("b_gnt", B_GNT, egb);
        chk("ram_en", RAM_ENABLE, c_en);
        chk("ram_we", RAM_WRITE, c_we);
        chk("ram_addr", RAM_ADDR, c_addr);
        chk("ram_din", RAM_DATA_IN, c_din);
        chk("a_rvalid", A_RVALID, rva_exp);
        chk("b_rvalid", B_RVALID, rvb_exp);
        if (rva_exp) chk("a_rdata", A_RDATA, r_exp);
        if (rvb_exp) chk("b_rdata", B_RDATA, r_exp);
        rva_exp = c_en && !c_we && !c_own;
        rvb_exp = c_en && !c_we && c_own;
        if (c_en && !c_we) r_exp = ref_mem[c_addr[11:0]];
        if (c_en && c_we) ref_mem[c_addr[11:0]] = c_din;
        ga = ega;
        gb = egb;
        if (ga || gb) begin
          c_en = 1;
          c_own = gb;
          c_we = gb ? B_WE : A_WE;
          c_addr = gb ? B_ADDR : A_ADDR;
          c_din = gb ? B_WDATA : A_WDATA;
          last_b = gb;
        end else begin
          c_en = 0;
          c_we = 0;
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
